// File: rtl/ddr_tx_serializer.sv
// Parallel-to-DDR serializer: double-buffered words are shifted out two bits
// per clock as registered D0/D1/CE_OUT for an output pad's DDR flop.
module ddr_tx_serializer #(
  parameter int         WIDTH     = 8,
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [1:0] IDLE_D    = 2'b00,
  parameter bit         IDLE_HOLD = 1'b0
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_LAST,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             D0,
  output logic             D1,
  output logic             CE_OUT,
  output logic             BUSY,
  output logic             UNDERRUN,
  input  logic             UNDERRUN_CLR
);

  localparam int BEATS = WIDTH / 2;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             hold_last_q, hold_last_d;
  logic             hold_v_q, hold_v_d;
  logic             sr_last_q, sr_last_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             underrun_q, underrun_d;
  logic             d0_q, d0_d, d1_q, d1_d, ce_q, ce_d;
  logic             accept_s, load_s, starve_s;

  // Pair presented on the current beat, ordered {D0, D1}.
  function automatic logic [1:0] head_pair(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      head_pair = w[WIDTH-1 -: 2];
    end else begin
      head_pair = {w[0], w[1]};
    end
  endfunction

  function automatic logic [WIDTH-1:0] shift_pair(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      shift_pair = {w[WIDTH-3:0], 2'b00};
    end else begin
      shift_pair = {2'b00, w[WIDTH-1:2]};
    end
  endfunction

  // Next-state: beat sequencing, holding-register handshake and output pattern.
  always_comb begin
    accept_s    = DIN_VALID & ~hold_v_q;
    load_s      = 1'b0;
    starve_s    = 1'b0;
    state_d     = state_q;
    sr_d        = sr_q;
    sr_last_d   = sr_last_q;
    bcnt_d      = bcnt_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;

    case (state_q)
      ST_IDLE: begin
        if (hold_v_q) begin
          load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bcnt_q == LAST_BEAT) begin
          if (hold_v_q) begin
            load_s = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            starve_s = ~sr_last_q;
          end
        end else begin
          sr_d   = shift_pair(sr_q);
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reload replaces the shift so the next word starts with no gap beat.
    if (load_s) begin
      state_d   = ST_RUN;
      sr_d      = hold_q;
      sr_last_d = hold_last_q;
      bcnt_d    = '0;
    end else begin
      sr_last_d = sr_last_q;
    end

    if (accept_s) begin
      hold_d      = DIN;
      hold_last_d = DIN_LAST;
      hold_v_d    = 1'b1;
    end else if (load_s) begin
      hold_v_d = 1'b0;
    end else begin
      hold_v_d = hold_v_q;
    end

    if (starve_s) begin
      underrun_d = 1'b1;
    end else if (UNDERRUN_CLR) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end

    // Pad outputs are precomputed from next state so they leave a flop directly.
    if (state_d == ST_RUN) begin
      {d0_d, d1_d} = head_pair(sr_d);
      ce_d         = 1'b1;
    end else begin
      {d0_d, d1_d} = IDLE_D;
      ce_d         = ~IDLE_HOLD;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_v_q    <= 1'b0;
      sr_q        <= '0;
      sr_last_q   <= 1'b0;
      bcnt_q      <= '0;
      underrun_q  <= 1'b0;
      d0_q        <= IDLE_D[1];
      d1_q        <= IDLE_D[0];
      ce_q        <= ~IDLE_HOLD;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_v_q    <= hold_v_d;
      sr_q        <= sr_d;
      sr_last_q   <= sr_last_d;
      bcnt_q      <= bcnt_d;
      underrun_q  <= underrun_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      ce_q        <= ce_d;
    end
  end

  assign DIN_READY = ~hold_v_q;
  assign BUSY      = (state_q == ST_RUN) | hold_v_q;
  assign UNDERRUN  = underrun_q;
  assign D0        = d0_q;
  assign D1        = d1_q;
  assign CE_OUT    = ce_q;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Directed bench: three serializer variants (MSB first, LSB first, idle-hold)
// share one stimulus stream and are checked against a hand-computed table.
module tb_ddr_tx_serializer;

  logic       C = 1'b0;
  logic       CLR_N = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DIN_LAST = 1'b0;
  logic       DIN_VALID = 1'b0;
  logic       UNDERRUN_CLR = 1'b0;

  logic m_rdy, m_d0, m_d1, m_ce, m_busy, m_und;
  logic l_rdy, l_d0, l_d1, l_ce, l_busy, l_und;
  logic h_rdy, h_d0, h_d1, h_ce, h_busy, h_und;

  int checks = 0;
  int failures = 0;

  always #5 C = ~C;

  ddr_tx_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_D(2'b00), .IDLE_HOLD(1'b0)) u_m (
    .C(C), .CLR_N(CLR_N), .DIN(DIN), .DIN_LAST(DIN_LAST), .DIN_VALID(DIN_VALID),
    .DIN_READY(m_rdy), .D0(m_d0), .D1(m_d1), .CE_OUT(m_ce), .BUSY(m_busy),
    .UNDERRUN(m_und), .UNDERRUN_CLR(UNDERRUN_CLR));

  ddr_tx_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_D(2'b10), .IDLE_HOLD(1'b0)) u_l (
    .C(C), .CLR_N(CLR_N), .DIN(DIN), .DIN_LAST(DIN_LAST), .DIN_VALID(DIN_VALID),
    .DIN_READY(l_rdy), .D0(l_d0), .D1(l_d1), .CE_OUT(l_ce), .BUSY(l_busy),
    .UNDERRUN(l_und), .UNDERRUN_CLR(UNDERRUN_CLR));

  ddr_tx_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_D(2'b00), .IDLE_HOLD(1'b1)) u_h (
    .C(C), .CLR_N(CLR_N), .DIN(DIN), .DIN_LAST(DIN_LAST), .DIN_VALID(DIN_VALID),
    .DIN_READY(h_rdy), .D0(h_d0), .D1(h_d1), .CE_OUT(h_ce), .BUSY(h_busy),
    .UNDERRUN(h_und), .UNDERRUN_CLR(UNDERRUN_CLR));

  // dm: {D0,D1} of the MSB-first instances; dl: {D0,D1} of the LSB-first one.
  typedef struct {
    logic       valid;
    logic [7:0] din;
    logic       last;
    logic       uclr;
    logic [1:0] dm;
    logic [1:0] dl;
    logic       ceh;
    logic       rdy;
    logic       busy;
    logic       und;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic valid, input logic [7:0] din, input logic last,
                              input logic uclr, input logic [1:0] dm, input logic [1:0] dl,
                              input logic ceh, input logic rdy, input logic busy, input logic und);
    vec_t v;
    v.valid = valid; v.din = din; v.last = last; v.uclr = uclr;
    v.dm = dm; v.dl = dl; v.ceh = ceh; v.rdy = rdy; v.busy = busy; v.und = und;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input vec_t e, input int idx);
    chk("d_msb",   idx, {1'b0, m_d0, m_d1}, {1'b0, e.dm});
    chk("d_hold",  idx, {1'b0, h_d0, h_d1}, {1'b0, e.dm});
    chk("d_lsb",   idx, {1'b0, l_d0, l_d1}, {1'b0, e.dl});
    chk("ce",      idx, {1'b0, m_ce, l_ce}, 3'b011);
    chk("ce_hold", idx, {2'b00, h_ce}, {2'b00, e.ceh});
    chk("ready",   idx, {m_rdy, l_rdy, h_rdy}, {3{e.rdy}});
    chk("busy",    idx, {m_busy, l_busy, h_busy}, {3{e.busy}});
    chk("underrun", idx, {m_und, l_und, h_und}, {3{e.und}});
  endtask

  task automatic drive(input vec_t e);
    DIN_VALID    = e.valid;
    DIN          = e.din;
    DIN_LAST     = e.last;
    UNDERRUN_CLR = e.uclr;
  endtask

  task automatic step(input vec_t e, input int idx);
    @(negedge C);
    check_all(e, idx);
    drive(e);
  endtask

  initial begin
    //                valid din    last uclr  dm     dl    ceh  rdy  busy und
    // single word A5, LAST
    tbl[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    // back-to-back FF then 00 (LAST) with DIN_VALID held
    tbl[6]  = mk(1'b1, 8'hFF, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 12; i < 16; i++)
      tbl[i] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    // starved word 3C (not LAST), then clear
    tbl[16] = mk(1'b1, 8'h3C, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[21] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[22] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[23] = mk(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    // second starved word; clear pulse lands on the setting edge
    tbl[24] = mk(1'b1, 8'h3C, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[25] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[26] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[27] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[28] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[29] = mk(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[30] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[31] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1);

    // reset state while CLR_N is held low across edges
    @(negedge C);
    check_all(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0), 0);
    CLR_N = 1'b1;

    for (int i = 0; i < 32; i++)
      step(tbl[i], i + 1);

    // reset asserted during beat 1 of A5; UNDERRUN is still set from above
    step(mk(1'b1, 8'hA5, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1), 100);
    step(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1), 101);
    step(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1), 102);
    @(negedge C);
    check_all(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1), 103);
    CLR_N = 1'b0;
    #1;
    check_all(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0), 104);
    @(posedge C);
    #1;
    check_all(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0), 105);
    @(negedge C);
    CLR_N = 1'b1;

    // clean restart with an asymmetric word 1E
    step(mk(1'b1, 8'h1E, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0), 106);
    step(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0), 107);
    step(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0), 108);
    step(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0), 109);
    step(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0), 110);
    step(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0), 111);
    step(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0), 112);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
